mux_arb_nb_ninput: RTL and testbench

Parametrised, registered N-input selector with valid/ready handshaking. It is the next generation of the datapath's 2-input 16-bit operand mux. It selects one of `N` `WIDTH`-bit sources, either by an explicit select (direct mode) or by a fair round-robin arbiter. The chosen word is captured into a single-entry output register with backpressure. It sits between multiple producers (register file, immediate path, memory read-back, I/O) and a shared consumer such as the ALU operand latch or a memory write port.

---
 rtl/mux_pkg.sv | 6 +
 rtl/rr_pick.sv | 21 ++
 rtl/mux_arb_nb_ninput.sv | 53 +++++
 tb/tb_mux_arb_nb_ninput.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// mux_pkg: shared mode encodings and limits for the N-input selector
package mux_pkg;
    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_RR     = 1'b1;
    localparam int   MUX_MAX_N   = 8;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotated priority search starting after Ptr, wrapping mod N
module rr_pick #(
    parameter int N = 4,
    localparam int SELW = $clog2(N)
) (
    input  logic [N-1:0]    Req,
    input  logic [SELW-1:0] Ptr,
    output logic [SELW-1:0] Grant,
    output logic            Grant_Valid
);
    // Walk the search order backwards so the earliest candidate overwrites last and wins
    always_comb begin
        Grant = '0;
        Grant_Valid = 1'b0;
        for (int k = N; k >= 1; k--)
            if (Req[(int'(Ptr) + k) % N]) begin
                Grant = SELW'((int'(Ptr) + k) % N);
                Grant_Valid = 1'b1;
            end
    end
endmodule

// File: rtl/mux_arb_nb_ninput.sv
// mux_arb_nb_ninput: registered N-input selector, direct or round-robin, valid/ready handshake
module mux_arb_nb_ninput
    import mux_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N = 4,
    localparam int SELW = $clog2(N)
) (
    input  logic                 CLK,
    input  logic                 Reset_n,
    input  logic [N*WIDTH-1:0]   In,
    input  logic [N-1:0]         In_Valid,
    output logic [N-1:0]         In_Ready,
    input  logic                 Mode,
    input  logic [SELW-1:0]      Op,
    output logic [WIDTH-1:0]     Output,
    output logic                 Out_Valid,
    input  logic                 Out_Ready,
    output logic [SELW-1:0]      Out_Src
);
    logic [SELW-1:0]      ptr, rr_grant, grant;
    logic                 rr_valid, grant_valid, accept;
    logic [2**SELW-1:0]   valid_pad;
    rr_pick #(.N(N)) u_pick (
        .Req(In_Valid),
        .Ptr(ptr),
        .Grant(rr_grant),
        .Grant_Valid(rr_valid)
    );
    // Padding lets a direct select beyond N-1 index safely and read as not valid
    assign valid_pad = (2**SELW)'(In_Valid);
    assign accept = !Out_Valid || Out_Ready;
    always_comb begin
        grant = Mode == MODE_RR ? rr_grant : Op;
        grant_valid = Mode == MODE_RR ? rr_valid : (int'(Op) < N) && valid_pad[Op];
        In_Ready = (accept && grant_valid) ? N'(1) << grant : '0;
    end
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            Output <= '0;
            Out_Valid <= 1'b0;
            Out_Src <= '0;
            ptr <= SELW'(N - 1);
        end else if (accept && grant_valid) begin
            Output <= In[int'(grant)*WIDTH +: WIDTH];
            Out_Src <= grant;
            Out_Valid <= 1'b1;
            ptr <= grant;
        end else if (Out_Ready) begin
            Out_Valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mux_arb_nb_ninput.sv
// tb_mux_arb_nb_ninput: directed table-driven checks on N=4 and N=3 instances
module tb_mux_arb_nb_ninput;
    logic        clk = 0;
    logic        rst_n = 0;
    always #5 clk = ~clk;

    logic [63:0] in4 = {16'h4003, 16'hBEEF, 16'h2001, 16'h1000};
    logic [3:0]  iv4 = 0, ir4;
    logic        mode4 = 0, ordy4 = 0, ov4;
    logic [1:0]  op4 = 0, src4;
    logic [15:0] out4;

    logic [47:0] in3 = {16'hC002, 16'hC001, 16'hC000};
    logic [2:0]  iv3 = 0, ir3;
    logic        mode3 = 0, ordy3 = 0, ov3;
    logic [1:0]  op3 = 0, src3;
    logic [15:0] out3;

    mux_arb_nb_ninput #(.WIDTH(16), .N(4)) dut4 (
        .CLK(clk), .Reset_n(rst_n), .In(in4), .In_Valid(iv4), .In_Ready(ir4),
        .Mode(mode4), .Op(op4), .Output(out4), .Out_Valid(ov4), .Out_Ready(ordy4), .Out_Src(src4)
    );
    mux_arb_nb_ninput #(.WIDTH(16), .N(3)) dut3 (
        .CLK(clk), .Reset_n(rst_n), .In(in3), .In_Valid(iv3), .In_Ready(ir3),
        .Mode(mode3), .Op(op3), .Output(out3), .Out_Valid(ov3), .Out_Ready(ordy3), .Out_Src(src3)
    );

    typedef struct {
        logic        mode;
        logic [1:0]  op;
        logic [3:0]  iv;
        logic        ordy;
        logic [3:0]  ir;
        logic        ov;
        logic [1:0]  src;
        logic [15:0] data;
    } vec_t;
    vec_t tv[21];

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        tv[0]  = '{0, 2, 4'b0100, 1, 4'b0100, 1, 2, 16'hBEEF};
        tv[1]  = '{0, 1, 4'b0010, 1, 4'b0010, 1, 1, 16'h2001};
        tv[2]  = '{1, 0, 4'b1111, 1, 4'b0100, 1, 2, 16'hBEEF};
        tv[3]  = '{1, 0, 4'b1111, 1, 4'b1000, 1, 3, 16'h4003};
        tv[4]  = '{1, 0, 4'b1111, 1, 4'b0001, 1, 0, 16'h1000};
        tv[5]  = '{1, 0, 4'b1111, 1, 4'b0010, 1, 1, 16'h2001};
        tv[6]  = '{1, 0, 4'b1111, 1, 4'b0100, 1, 2, 16'hBEEF};
        tv[7]  = '{1, 0, 4'b1111, 1, 4'b1000, 1, 3, 16'h4003};
        tv[8]  = '{1, 0, 4'b1111, 1, 4'b0001, 1, 0, 16'h1000};
        tv[9]  = '{1, 0, 4'b1111, 1, 4'b0010, 1, 1, 16'h2001};
        tv[10] = '{1, 0, 4'b1111, 1, 4'b0100, 1, 2, 16'hBEEF};
        tv[11] = '{1, 0, 4'b1111, 1, 4'b1000, 1, 3, 16'h4003};
        tv[12] = '{1, 0, 4'b0000, 1, 4'b0000, 0, 3, 16'h4003};
        tv[13] = '{1, 0, 4'b1010, 0, 4'b0010, 1, 1, 16'h2001};
        tv[14] = '{1, 0, 4'b1010, 0, 4'b0000, 1, 1, 16'h2001};
        tv[15] = '{1, 0, 4'b1010, 0, 4'b0000, 1, 1, 16'h2001};
        tv[16] = '{1, 0, 4'b1010, 0, 4'b0000, 1, 1, 16'h2001};
        tv[17] = '{1, 0, 4'b1010, 1, 4'b1000, 1, 3, 16'h4003};
        tv[18] = '{0, 0, 4'b1110, 1, 4'b0000, 0, 3, 16'h4003};
        tv[19] = '{0, 3, 4'b1000, 0, 4'b1000, 1, 3, 16'h4003};
        tv[20] = '{0, 0, 4'b0001, 0, 4'b0000, 1, 3, 16'h4003};

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        mode4 = 1; iv4 = 4'b1111;
        #1;
        chk("rst_output", 32'(out4), 0);
        chk("rst_out_valid", 32'(ov4), 0);
        chk("rst_out_src", 32'(src4), 0);
        chk("rst_in_ready", 32'(ir4), 32'b0001);
        chk("rst3_out_valid", 32'(ov3), 0);
        @(negedge clk);
        rst_n = 1;
        iv4 = 0;

        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            mode4 = tv[i].mode; op4 = tv[i].op; iv4 = tv[i].iv; ordy4 = tv[i].ordy;
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(ir4), 32'(tv[i].ir));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_out_valid", i), 32'(ov4), 32'(tv[i].ov));
            chk($sformatf("v%0d_out_src", i), 32'(src4), 32'(tv[i].src));
            chk($sformatf("v%0d_output", i), 32'(out4), 32'(tv[i].data));
        end

        // N=3: out-of-range direct select, then round-robin wraps mod 3
        @(negedge clk);
        mode3 = 0; op3 = 3; iv3 = 3'b111; ordy3 = 1;
        #1 chk("n3_op3_in_ready", 32'(ir3), 0);
        @(posedge clk);
        #1 chk("n3_op3_out_valid", 32'(ov3), 0);
        @(negedge clk);
        op3 = 2;
        #1 chk("n3_op2_in_ready", 32'(ir3), 32'b100);
        @(posedge clk);
        #1;
        chk("n3_op2_out_valid", 32'(ov3), 1);
        chk("n3_op2_out_src", 32'(src3), 2);
        chk("n3_op2_output", 32'(out3), 32'hC002);
        @(negedge clk);
        mode3 = 1;
        #1 chk("n3_wrap_in_ready", 32'(ir3), 32'b001);
        @(posedge clk);
        #1;
        chk("n3_wrap_out_src", 32'(src3), 0);
        chk("n3_wrap_output", 32'(out3), 32'hC000);

        // async reset mid-cycle while dut4 holds a stalled word
        @(negedge clk);
        mode4 = 1; iv4 = 4'b1111; ordy4 = 0;
        #1 chk("stall_in_ready", 32'(ir4), 0);
        #2 rst_n = 0;
        #1;
        chk("arst_out_valid", 32'(ov4), 0);
        chk("arst_output", 32'(out4), 0);
        chk("arst_out_src", 32'(src4), 0);
        chk("arst_in_ready", 32'(ir4), 32'b0001);
        @(negedge clk);
        rst_n = 1; ordy4 = 1;
        #1 chk("post_rst_in_ready", 32'(ir4), 32'b0001);
        @(posedge clk);
        #1;
        chk("post_rst_out_src", 32'(src4), 0);
        chk("post_rst_output", 32'(out4), 32'h1000);
        chk("post_rst_out_valid", 32'(ov4), 1);
        @(negedge clk);
        #1 chk("post_rst_next_ready", 32'(ir4), 32'b0010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
